// File: rtl/instruction_sequencer.sv
// Three-phase (fetch low, fetch high, execute) hardwired control unit for a
// small 16-bit datapath. The control word is decoded from the current state and IROut.
module instruction_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic        Halted,
  output logic [2:0]  State,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_BRZ = 4'h3;
  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_STL = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [3:0] opcode_s;
  logic [1:0] rd_s;
  logic [1:0] rs_s;
  logic [3:0] rd_en_n_s;
  logic       zero_s;

  assign opcode_s  = IROut[15:12];
  assign rd_s      = IROut[11:10];
  assign rs_s      = IROut[9:8];
  assign zero_s    = Flags[3];
  // Rd = 0 selects R1, which sits on bit 3 of the active-low enable vector.
  assign rd_en_n_s = ~(4'b1000 >> rd_s);

  assign State  = state_q;
  assign Halted = (state_q == S_HALT);

  // Next-state sequencing: IDLE -> T0 -> T1 -> T2 -> T0 ..., HLT parks in HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Run) begin
          state_d = S_T0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (opcode_s == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control word decode; any field not set below keeps its idle value.
  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b1111;
    RF_ScrSel   = 4'b1111;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 3'b000;
    ARF_RegSel  = 3'b111;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    case (state_q)
      S_T0, S_T1: begin
        Mem_CS      = 1'b0;
        ARF_OutDSel = 2'b00;
        IR_Write    = 1'b1;
        IR_LH       = (state_q == S_T1);
        ARF_RegSel  = 3'b011;
        ARF_FunSel  = 3'b001;
      end
      S_T2: begin
        case (opcode_s)
          OP_LDI: begin
            MuxASel   = 2'b11;
            RF_FunSel = 3'b010;
            RF_RegSel = rd_en_n_s;
          end
          OP_ADD: begin
            RF_OutASel = {1'b0, rd_s};
            RF_OutBSel = {1'b0, rs_s};
            ALU_FunSel = 5'b10100;
            ALU_WF     = 1'b1;
            MuxASel    = 2'b00;
            RF_FunSel  = 3'b010;
            RF_RegSel  = rd_en_n_s;
          end
          OP_BRZ: begin
            if (zero_s) begin
              MuxBSel    = 2'b11;
              ARF_FunSel = 3'b010;
              ARF_RegSel = 3'b011;
            end else begin
              ARF_RegSel = 3'b111;
            end
          end
          OP_BRA: begin
            MuxBSel    = 2'b11;
            ARF_FunSel = 3'b010;
            ARF_RegSel = 3'b011;
          end
          OP_STL: begin
            RF_OutASel  = {1'b0, rs_s};
            ALU_FunSel  = 5'b10000;
            MuxCSel     = 1'b0;
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          default: begin
            Mem_CS = 1'b1;
          end
        endcase
      end
      default: begin
        Mem_CS = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer against a phase-counting reference
// model, plus directed checks of the named decode vectors, HALT and async reset.
module tb_instruction_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic        Halted;
  logic [2:0]  State;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;

  instruction_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IROut(IROut), .Flags(Flags),
    .Halted(Halted), .State(State),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
    .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int m_state = 0;   // model state code: 0 IDLE, 1 T0, 2 T1, 3 T2, 4 HALT

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [41:0] dut_word();
    return {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
            ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
            IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};
  endfunction

  // Reference control word built field by field from the instruction rules.
  function automatic logic [41:0] ref_word(input int st, input logic [15:0] ir, input logic [3:0] fl);
    logic [2:0] oa, ob, rff, arff, arrs;
    logic [3:0] rrs;
    logic [4:0] alu;
    logic [1:0] dsel, ma, mb;
    logic       wf, lh, irw, wr, cs;
    int op, rd, rs;
    oa = 3'b000; ob = 3'b000; rff = 3'b000; rrs = 4'b1111; alu = 5'b00000;
    wf = 1'b0; dsel = 2'b00; arff = 3'b000; arrs = 3'b111; lh = 1'b0;
    irw = 1'b0; wr = 1'b0; cs = 1'b1; ma = 2'b00; mb = 2'b00;
    op = int'(ir[15:12]); rd = int'(ir[11:10]); rs = int'(ir[9:8]);
    if (st == 1 || st == 2) begin
      cs = 1'b0; irw = 1'b1; lh = (st == 2); arrs = 3'b011; arff = 3'b001;
    end else if (st == 3) begin
      if (op == 1 || op == 2) begin
        rff = 3'b010;
        rrs[3 - rd] = 1'b0;
        ma = (op == 1) ? 2'b11 : 2'b00;
        if (op == 2) begin
          oa = 3'(rd); ob = 3'(rs); alu = 5'b10100; wf = 1'b1;
        end
      end else if (op == 4 || (op == 3 && fl[3])) begin
        mb = 2'b11; arff = 3'b010; arrs = 3'b011;
      end else if (op == 5) begin
        oa = 3'(rs); alu = 5'b10000; dsel = 2'b10; cs = 1'b0; wr = 1'b1;
      end
    end
    return {oa, ob, rff, rrs, 4'b1111, alu, wf, 2'b00, dsel, arff, arrs,
            lh, irw, wr, cs, ma, mb, 1'b0};
  endfunction

  // One clock cycle: drive at posedge+1, compare at posedge+3, advance model at the edge.
  task automatic step(input logic run_v, input logic [15:0] ir, input logic [3:0] fl);
    Run = run_v; IROut = ir; Flags = fl;
    #2;
    check("state", 64'(State), 64'(m_state));
    check("halted", 64'(Halted), 64'(m_state == 4));
    check("ctrl", 64'(dut_word()), 64'(ref_word(m_state, ir, fl)));
    @(posedge Clock);
    case (m_state)
      0: m_state = run_v ? 1 : 0;
      3: m_state = (ir[15:12] == 4'hF) ? 4 : 1;
      4: m_state = 4;
      default: m_state = m_state + 1;
    endcase
    #1;
  endtask

  // Reset pulse spanning one edge with Run held high; state must clear at once.
  task automatic reset_pulse();
    Reset = 1'b0; Run = 1'b1;
    #1;
    m_state = 0;
    check("rst_state", 64'(State), 64'd0);
    check("rst_halted", 64'(Halted), 64'd0);
    check("rst_ctrl", 64'(dut_word()), 64'(ref_word(0, IROut, Flags)));
    check("rst_memcs", 64'(Mem_CS), 64'd1);
    check("rst_rfregsel", 64'(RF_RegSel), 64'hF);
    check("rst_arfregsel", 64'(ARF_RegSel), 64'h7);
    @(posedge Clock);
    #1;
    check("rst_hold", 64'(State), 64'd0);
    Reset = 1'b1;
  endtask

  initial begin
    logic [15:0] ir;
    int op;
    Reset = 1'b0; Run = 1'b0; IROut = 16'h0000; Flags = 4'h0;
    @(posedge Clock);
    #1;
    reset_pulse();

    // Release with Run=1 -> T0 on next edge, then LDI R4,0x85.
    step(1'b1, 16'h0000, 4'h0);
    step(1'b0, 16'h0000, 4'h0);
    step(1'b0, 16'h0000, 4'h0);
    IROut = 16'h1C85; #2;
    check("ldi_muxa", 64'(MuxASel), 64'h3);
    check("ldi_rffun", 64'(RF_FunSel), 64'h2);
    check("ldi_regsel", 64'(RF_RegSel), 64'hE);
    step(1'b0, 16'h1C85, 4'h0);
    check("ldi_next", 64'(State), 64'd1);

    // ADD R1,R2
    step(1'b0, 16'h0000, 4'h0);
    step(1'b0, 16'h0000, 4'h0);
    IROut = 16'h2100; #2;
    check("add_outa", 64'(RF_OutASel), 64'h0);
    check("add_outb", 64'(RF_OutBSel), 64'h1);
    check("add_alu", 64'(ALU_FunSel), 64'h14);
    check("add_wf", 64'(ALU_WF), 64'h1);
    check("add_regsel", 64'(RF_RegSel), 64'h7);
    step(1'b0, 16'h2100, 4'h0);

    // BRZ taken and not taken
    step(1'b1, 16'h0000, 4'h0);
    step(1'b0, 16'h0000, 4'h0);
    IROut = 16'h3010; Flags = 4'b1000; #2;
    check("brz_t_regsel", 64'(ARF_RegSel), 64'h3);
    check("brz_t_fun", 64'(ARF_FunSel), 64'h2);
    check("brz_t_muxb", 64'(MuxBSel), 64'h3);
    Flags = 4'b0000; #1;
    check("brz_n_regsel", 64'(ARF_RegSel), 64'h7);
    step(1'b0, 16'h3010, 4'b0000);

    // HLT, then HALT held while Run toggles
    step(1'b0, 16'h0000, 4'h0);
    step(1'b0, 16'h0000, 4'h0);
    step(1'b0, 16'hF000, 4'h0);
    check("hlt_state", 64'(State), 64'd4);
    check("hlt_halted", 64'(Halted), 64'd1);
    for (int i = 0; i < 6; i++) step(1'(i % 2), 16'h1C85, 4'hF);

    // Reset mid-T1
    reset_pulse();
    step(1'b1, 16'h0000, 4'h0);
    step(1'b0, 16'h0000, 4'h0);
    check("t1_before_rst", 64'(State), 64'd2);
    reset_pulse();

    // Randomized run; occasional resets, frequent recovery from HALT
    for (int i = 0; i < 3000; i++) begin
      if ((m_state == 4 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else begin
        ir = 16'($urandom);
        op = int'(ir[15:12]);
        if (op == 15 && $urandom_range(0, 3) != 0) ir[15:12] = 4'h0;
        step(1'($urandom_range(0, 3) != 0), ir, 4'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL: Clock  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: Reset  in  1  asynchronous, active-low; 0 forces state IDLE immediately.
REQ-003 SHALL: Run  in  1  start request, sampled in IDLE only.
REQ-004 SHALL: IROut  in  16  instruction register contents: [15:12] opcode, [11:10] Rd, [9:8] Rs, [7:0] imm.
REQ-005 SHALL: Flags  in  4  ALU flags {Z,C,N,O}; Z = Flags[3].
REQ-006 SHALL: Halted  out  1  high while in HALT.
REQ-007 SHALL: State  out  3  current state code: IDLE=0, T0=1, T1=2, T2=3, HALT=4.
REQ-008 SHALL: RF_OutASel  out  3  RF port A source; 3'b000..3'b011 = R1..R4.
REQ-009 SHALL: RF_OutBSel  out  3  RF port B source; same encoding.
REQ-010 SHALL: RF_FunSel  out  3  RF function; 3'b010 = 16-bit load.
REQ-011 SHALL: RF_RegSel  out  4  RF write enables, active-low; bit3..bit0 = R1..R4.
REQ-012 SHALL: RF_ScrSel  out  4  scratch enables, active-low; constant 4'b1111.
REQ-013 SHALL: ALU_FunSel  out  5  ALU op; 5'b10000 = pass A, 5'b10100 = A+B.
REQ-014 SHALL: ALU_WF  out  1  ALU flag write enable.
REQ-015 SHALL: ARF_OutCSel  out  2  ARF port C source; constant 2'b00.
REQ-016 SHALL: ARF_OutDSel  out  2  memory address source; 2'b00 = PC, 2'b10 = AR.
REQ-017 SHALL: ARF_FunSel  out  3  ARF function; 3'b001 = increment, 3'b010 = load.
REQ-018 SHALL: ARF_RegSel  out  3  ARF enables, active-low; bit2 = PC, bit1 = AR, bit0 = SP.
REQ-019 SHALL: IR_LH  out  1  IR half select; 0 = low byte, 1 = high byte.
REQ-020 SHALL: IR_Write  out  1  IR byte write enable.
REQ-021 SHALL: Mem_WR  out  1  0 = read, 1 = write.
REQ-022 SHALL: Mem_CS  out  1  memory chip select, active-low.
REQ-023 SHALL: MuxASel / MuxBSel  out  2 each  00 = ALUOut, 11 = sign-extended IROut[7:0].
REQ-024 SHALL: MuxCSel  out  1  0 = ALUOut[7:0] to memory.

Function
REQ-025 SHALL: idle control word = all RegSel bits 1, Mem_CS=1, Mem_WR=0, IR_Write=0, ALU_WF=0, all other controls 0; driven in IDLE, HALT and for every field not named below.
REQ-026 SHALL: IDLE -> T0 when Run=1 at the clock edge; otherwise stay in IDLE.
REQ-027 SHALL: T0 (fetch low): Mem_CS=0, Mem_WR=0, ARF_OutDSel=00, IR_Write=1, IR_LH=0, ARF_RegSel=3'b011, ARF_FunSel=001 (PC++); -> T1.
REQ-028 SHALL: T1 (fetch high): same as T0 except IR_LH=1; -> T2.
REQ-029 SHALL: T2 (execute) decodes IROut combinationally and -> T0, except HLT, which goes -> HALT.
REQ-030 SHALL: opcode 0x0 NOP and opcodes 0x6-0xE (undefined) drive the idle word in T2.
REQ-031 SHALL: 0x1 LDI: MuxASel=11, RF_FunSel=010, RF_RegSel low on Rd bit only.
REQ-032 SHALL: 0x2 ADD: RF_OutASel=Rd, RF_OutBSel=Rs, ALU_FunSel=10100, ALU_WF=1, MuxASel=00, RF load into Rd.
REQ-033 SHALL: 0x3 BRZ: if Z=1, MuxBSel=11, ARF_FunSel=010, ARF_RegSel=3'b011 (PC<-sext imm); if Z=0, idle word.
REQ-034 SHALL: 0x4 BRA: PC load identical to taken BRZ, unconditionally.
REQ-035 SHALL: 0x5 STL: RF_OutASel=Rs, ALU_FunSel=10000, MuxCSel=0, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
REQ-036 SHALL: 0xF HLT: idle word in T2; HALT is exited only by Reset.
REQ-037 SHALL: every instruction takes exactly 3 cycles (T0, T1, T2); Flags are sampled in T2 only.
REQ-038 SHALL: Run is ignored outside IDLE; deasserting Run mid-instruction does not stall execution.

Reset
REQ-039 SHALL: Reset=0 forces State=0, Halted=0 and the idle control word asynchronously, including mid-fetch or mid-execute; release resumes in IDLE.

Verification
REQ-040 SHALL: Reset low, Run=1 -> State=0, Mem_CS=1, RF_RegSel=1111, ARF_RegSel=111; release with Run=1 -> State=1 on the next edge.
REQ-041 SHALL: IROut=16'h1C85 (LDI R4, 0x85) in T2 -> MuxASel=11, RF_FunSel=010, RF_RegSel=4'b1110; next State=1.
REQ-042 SHALL: IROut=16'h2100 (ADD R1, R2) in T2 -> RF_OutASel=000, RF_OutBSel=001, ALU_FunSel=10100, ALU_WF=1, RF_RegSel=0111.
REQ-043 SHALL: IROut=16'h3010 (BRZ): Flags=4'b1000 -> ARF_RegSel=011, ARF_FunSel=010, MuxBSel=11; Flags=4'b0000 -> ARF_RegSel=111.
REQ-044 SHALL: IROut=16'hF000 in T2 -> next State=4, Halted=1, held with Run toggling; Reset pulse asserted in T1 -> State=0 immediately.
